tx_frame_padder: RTL and testbench
==================================

Name: tx_frame_padder

Overview:
Sits directly upstream of tx_interface on the transmit path and feeds its FIFO-side AXI4-Stream input. It passes application frames through unchanged. Frames shorter than the Ethernet minimum (60 bytes, excluding FCS) are extended with pad bytes before they reach the store-and-forward buffer and the XGMAC. A single registered output stage gives a fixed 1-cycle latency, and the output honours downstream tready.

Parameters:
MIN_BYTES, 60, minimum frame length in bytes; legal range 8..2040.
PAD_BYTE, 8'h00, value written into every pad byte.

Ports:
user_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  64  application frame data; byte 0 in [7:0]
s_axis_tkeep  in  8  byte enables; contiguous from bit 0
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  input accept
m_axis_tdata  out  64  to tx_interface axi_str_tdata_from_fifo
m_axis_tkeep  out  8  to tx_interface axi_str_tkeep_from_fifo
m_axis_tvalid  out  1  to tx_interface axi_str_tvalid_from_fifo
m_axis_tlast  out  1  to tx_interface axi_str_tlast_from_fifo
m_axis_tready  in  1  from tx_interface axi_str_tready_to_fifo
stat_frames  out  32  frames emitted (see Optional Feature)
stat_padded  out  32  frames that needed padding (see Optional Feature)

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, state=PASS, beat_cnt=0, stat counters=0. Reset is honoured in any state. A partially sent frame is abandoned, and no tlast is emitted for it.
- Output register "free" = ~m_axis_tvalid | m_axis_tready.
- Register load: the output register loads on free & (input accepted | pad beat generated). It clears m_axis_tvalid on m_axis_tready & ~load.
- s_axis_tready = free & (state==PASS). It is combinational on m_axis_tready, with no combinational path from s_axis_tvalid.
- Latency: an input beat accepted in cycle N is presented at the output in cycle N+1. Output data, keep and last hold stable while tvalid=1 & tready=0.
- beat_cnt: 8-bit count of beats already emitted in the current frame. It increments per loaded beat, saturates at 255, and clears to 0 after the tlast beat loads.
- bytes_so_far = 8*beat_cnt + popcount(beat tkeep). Use a 12-bit width.
- State PASS, non-last beat: forward data, keep and last unchanged.
- State PASS, last beat, bytes_so_far >= MIN_BYTES: forward unchanged, tlast=1, stay in PASS.
- State PASS, last beat, bytes_so_far < MIN_BYTES: compute end_beat = ceil(MIN_BYTES/8)-1 and end_keep = low-aligned mask of MIN_BYTES-8*end_beat bytes.
  - Fill disabled bytes of this beat with PAD_BYTE.
  - If beat_cnt==end_beat: tkeep=end_keep, tlast=1, stay in PASS. If the beat already had more bytes than end_keep, keep its original tkeep.
  - Otherwise: tkeep=8'hFF, tlast=0, go to PAD.
- State PAD: s_axis_tready=0. Each free cycle emits a beat of all PAD_BYTE.
  - Beats before end_beat: tkeep=FF, tlast=0.
  - At beat_cnt==end_beat: tkeep=end_keep, tlast=1, then return to PASS.
- A tlast beat with tkeep=0 counts 0 bytes. A single such beat becomes a full MIN_BYTES frame.
- Back-to-back frames: the first beat of the next frame may be accepted in the cycle the previous tlast loads, provided state is PASS.
- Downstream backpressure mid-PAD stalls pad generation without skipping or duplicating beats.

Optional Feature:
- TX_PAD_STATS_EN defined: stat_frames increments on each output tlast handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast). stat_padded increments on the same handshake when that frame was padded. Both are 32-bit, wrap at 2^32, and are cleared by reset.
- TX_PAD_STATS_EN undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- 64-byte frame (8 beats, last tkeep=FF), m_axis_tready=1 -> output identical, 8 beats, each 1 cycle after input; stat_padded unchanged.
- 20-byte frame (FF, FF, 0F last) -> 8 output beats. Beat 2 has bytes 4..7 = 00 and keep FF. Beats 3..6 are zero with keep FF. Beat 7 is zero with keep 0F and tlast=1. s_axis_tready=0 during beats 3..7.
- Single beat, tkeep=00, tlast=1 -> 8 beats of zero, last keep 0F; stat_padded=1 and stat_frames=1 with TX_PAD_STATS_EN.
- 60-byte frame ending keep 0F at beat 7 -> passes unchanged. A 57-byte frame (beat 7 keep 01) -> beat 7 data byte 0 is preserved, bytes 1..3 = PAD_BYTE, keep 0F, tlast=1.
- 20-byte frame with m_axis_tready toggling 1010... -> same 8 beats as scenario 2, data stable while stalled, no lost or duplicated beats.
- Reset asserted during PAD at beat 4 -> next cycle m_axis_tvalid=0. A following 64-byte frame passes unchanged with beat_cnt restarting at 0.

Source files
------------

// File: rtl/tx_frame_padder.sv
// Transmit-path frame padder: extends frames shorter than MIN_BYTES with PAD_BYTE, 1-cycle registered output.
// Define TX_PAD_STATS_EN to build the stat_frames / stat_padded counters; otherwise both ports read 0.
module tx_frame_padder #(
  parameter int          MIN_BYTES = 60,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_padded
);

  typedef enum logic {PASS = 1'b0, PAD = 1'b1} state_t;

  localparam int         END_BEAT_I = (MIN_BYTES + 7) / 8 - 1;
  localparam int         END_BYTES  = MIN_BYTES - 8 * END_BEAT_I;
  localparam int         END_KEEP_I = (1 << END_BYTES) - 1;
  localparam logic [7:0] END_BEAT   = 8'(END_BEAT_I);
  localparam logic [7:0] END_KEEP   = 8'(END_KEEP_I);
  localparam logic [11:0] MIN_W     = 12'(MIN_BYTES);

  state_t      state_q, state_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  keep_q, keep_d;
  logic        last_q, last_d;
  logic        valid_q;

  logic        free, accept, pad_gen, load;
  logic [3:0]  kcnt;
  logic [11:0] bytes_so_far;
  logic        short_last;

  assign free          = ~valid_q | m_axis_tready;
  assign s_axis_tready = free & (state_q == PASS);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pad_gen       = free & (state_q == PAD);
  assign load          = accept | pad_gen;

  always_comb begin
    kcnt = 4'd0;
    for (int i = 0; i < 8; i++) kcnt = kcnt + {3'b000, s_axis_tkeep[i]};
  end

  assign bytes_so_far = {1'b0, beat_cnt_q, 3'b000} + {8'd0, kcnt};
  assign short_last   = s_axis_tlast & (bytes_so_far < MIN_W);

  always_comb begin
    data_d  = s_axis_tdata;
    keep_d  = s_axis_tkeep;
    last_d  = s_axis_tlast;
    state_d = state_q;
    if (state_q == PAD) begin
      data_d = {8{PAD_BYTE}};
      if (beat_cnt_q == END_BEAT) begin
        keep_d  = END_KEEP;
        last_d  = 1'b1;
        state_d = PASS;
      end else begin
        keep_d = 8'hFF;
        last_d = 1'b0;
      end
    end else if (short_last) begin
      for (int i = 0; i < 8; i++)
        if (!s_axis_tkeep[i]) data_d[i*8 +: 8] = PAD_BYTE;
      // tkeep is contiguous, so OR-ing keeps a wider original mask intact
      if (beat_cnt_q == END_BEAT) begin
        keep_d = s_axis_tkeep | END_KEEP;
      end else begin
        keep_d  = 8'hFF;
        last_d  = 1'b0;
        state_d = PAD;
      end
    end
  end

  always_comb begin
    if (last_d)                  beat_cnt_d = 8'd0;
    else if (beat_cnt_q == 8'hFF) beat_cnt_d = 8'hFF;
    else                         beat_cnt_d = beat_cnt_q + 8'd1;
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q    <= PASS;
      beat_cnt_q <= 8'd0;
      data_q     <= 64'd0;
      keep_q     <= 8'd0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (load) begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      valid_q    <= 1'b1;
    end else if (m_axis_tready) begin
      valid_q    <= 1'b0;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;

`ifdef TX_PAD_STATS_EN
  logic        padded_d, padded_q;
  logic [31:0] frames_q, pads_q;

  // padded_q tags the beat currently in the output register as belonging to a padded frame
  assign padded_d = (state_q == PAD) | short_last;

  always_ff @(posedge user_clk) begin
    if (reset) begin
      padded_q <= 1'b0;
      frames_q <= 32'd0;
      pads_q   <= 32'd0;
    end else begin
      if (load) padded_q <= padded_d;
      if (valid_q & m_axis_tready & last_q) begin
        frames_q <= frames_q + 32'd1;
        if (padded_q) pads_q <= pads_q + 32'd1;
      end
    end
  end

  assign stat_frames = frames_q;
  assign stat_padded = pads_q;
`else
  assign stat_frames = 32'd0;
  assign stat_padded = 32'd0;
`endif

endmodule

// File: tb/tb_tx_frame_padder.sv
// Scoreboard bench for tx_frame_padder: table of frames, expected beats queued at input accept.
module tb_tx_frame_padder;

  logic        user_clk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] stat_frames;
  logic [31:0] stat_padded;

  tx_frame_padder dut (
    .user_clk      (user_clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .stat_frames   (stat_frames),
    .stat_padded   (stat_padded)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;       // expected first-present cycle, -1 for generated pad beats
    logic        padphase;  // DUT must hold s_axis_tready low while this beat is presented
  } beat_t;

  typedef struct {
    int          nbeats;
    logic [7:0]  lastkeep;
    logic        padded;
  } frame_t;

  typedef struct {
    int          nb;
    logic [7:0]  in_keep;
    int          mode;
    int          idle;
    int          exp_nout;
    logic [7:0]  exp_lk;
    logic        exp_pad;
  } vec_t;

  beat_t  exp_q[$];
  frame_t frm_q[$];
  vec_t   tab[10];

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int exp_frames = 0;
  int exp_padded = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input int c, input logic pp);
    beat_t e;
    e.data = d; e.keep = k; e.last = l; e.cyc = c; e.padphase = pp;
    exp_q.push_back(e);
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 2 == 0);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge user_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      drive_ready();
    end
  endtask

  // Returns at negedge+1 with the beat set up so that the coming posedge accepts it.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int guard = 0;
    forever begin
      @(negedge user_clk);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      drive_ready();
      #1;
      if (s_axis_tready) break;
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL accept_timeout: actual=no_accept required=accept (cycle %0d)", cyc);
        break;
      end
    end
  endtask

  task automatic send_frame(input int nb, input logic [7:0] lk, input int exp_nout,
                            input logic [7:0] exp_lk, input logic exp_pad);
    frame_t f;
    int total;
    logic sh;
    f.nbeats = exp_nout; f.lastkeep = exp_lk; f.padded = exp_pad;
    frm_q.push_back(f);
    total = 8 * (nb - 1) + $countones(lk);
    sh = (total < 60);
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d, pd;
      logic [7:0]  k;
      logic        l;
      d = {$urandom(), $urandom()};
      l = (b == nb - 1);
      k = l ? lk : 8'hFF;
      send_beat(d, k, l);
      if (!l || !sh) begin
        push_beat(d, k, l, cyc + 1, 1'b0);
      end else begin
        pd = d;
        for (int j = 0; j < 8; j++) if (!k[j]) pd[j*8 +: 8] = 8'h00;
        if (b >= 7) begin
          push_beat(pd, k | 8'h0F, 1'b1, cyc + 1, 1'b0);
        end else begin
          push_beat(pd, 8'hFF, 1'b0, cyc + 1, 1'b1);
          for (int p = b + 1; p <= 7; p++)
            push_beat(64'd0, (p == 7) ? 8'h0F : 8'hFF, (p == 7), -1, (p != 7));
        end
      end
    end
  endtask

  // Monitor / scoreboard: samples two time units after the falling edge.
  initial begin
    logic        prev_stall = 1'b0;
    logic [63:0] hd = 64'd0;
    logic [7:0]  hk = 8'd0;
    logic        hl = 1'b0;
    int          first_cyc = 0;
    int          nbeats = 0;
    beat_t       e;
    frame_t      f;
    forever begin
      @(negedge user_clk);
      #2;
      if (reset) begin
        prev_stall = 1'b0;
        nbeats = 0;
        exp_frames = 0;
        exp_padded = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(m_axis_tvalid), 64'd1);
          check("hold_data", m_axis_tdata, hd);
          check("hold_keep", 64'(m_axis_tkeep), 64'(hk));
          check("hold_last", 64'(m_axis_tlast), 64'(hl));
        end
        if (m_axis_tvalid) begin
          if (!prev_stall) first_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: actual=%0h required=no_beat (cycle %0d)", m_axis_tdata, cyc);
          end else begin
            if (exp_q[0].padphase) check("s_tready_in_pad", 64'(s_axis_tready), 64'd0);
            if (m_axis_tready) begin
              e = exp_q.pop_front();
              check("out_data", m_axis_tdata, e.data);
              check("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
              check("out_last", 64'(m_axis_tlast), 64'(e.last));
              if (e.cyc >= 0) check("latency", 64'(first_cyc), 64'(e.cyc));
              nbeats++;
              if (m_axis_tlast) begin
                if (frm_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_frame: actual=tlast required=none (cycle %0d)", cyc);
                end else begin
                  f = frm_q.pop_front();
                  check("frame_beats", 64'(nbeats), 64'(f.nbeats));
                  check("frame_last_keep", 64'(m_axis_tkeep), 64'(f.lastkeep));
                  exp_frames++;
                  if (f.padded) exp_padded++;
                end
                nbeats = 0;
              end
            end
          end
        end
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast;
      end
    end
  end

  initial begin
    int guard;
    //         nb  in_keep mode idle nout exp_lk exp_pad
    tab[0] = '{8,  8'hFF,  0,   1,   8,   8'hFF, 1'b0};   // 64 bytes, pass-through
    tab[1] = '{3,  8'h0F,  0,   0,   8,   8'h0F, 1'b1};   // 20 bytes
    tab[2] = '{1,  8'h00,  0,   2,   8,   8'h0F, 1'b1};   // empty last beat
    tab[3] = '{8,  8'h0F,  0,   0,   8,   8'h0F, 1'b0};   // exactly 60 bytes
    tab[4] = '{8,  8'h01,  0,   0,   8,   8'h0F, 1'b1};   // 57 bytes
    tab[5] = '{3,  8'h0F,  1,   2,   8,   8'h0F, 1'b1};   // 20 bytes, tready 1010
    tab[6] = '{10, 8'h3F,  2,   0,   10,  8'h3F, 1'b0};   // 78 bytes, random tready
    tab[7] = '{7,  8'hFF,  2,   1,   8,   8'h0F, 1'b1};   // 56 bytes, full last beat
    tab[8] = '{8,  8'h00,  1,   0,   8,   8'h0F, 1'b1};   // 56 bytes, empty beat 7
    tab[9] = '{2,  8'h01,  2,   3,   8,   8'h0F, 1'b1};   // 9 bytes

    reset = 1'b1;
    s_axis_tdata = 64'd0; s_axis_tkeep = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge user_clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_stat_frames", 64'(stat_frames), 64'd0);
    check("rst_stat_padded", 64'(stat_padded), 64'd0);
    @(negedge user_clk);
    reset = 1'b0;
    #1;
    check("idle_s_tready", 64'(s_axis_tready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      ready_mode = tab[i].mode;
      send_frame(tab[i].nb, tab[i].in_keep, tab[i].exp_nout, tab[i].exp_lk, tab[i].exp_pad);
      idle(tab[i].idle);
    end

    // Reset while pad beat 4 of a 20-byte frame is in the output register
    ready_mode = 0;
    idle(20);
    send_frame(3, 8'h0F, 8, 8'h0F, 1'b1);
    @(negedge user_clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; drive_ready();
    @(negedge user_clk);
    drive_ready();
    @(negedge user_clk);
    drive_ready();
    reset = 1'b1;
    exp_q.delete();
    frm_q.delete();
    @(negedge user_clk);
    reset = 1'b0;
    drive_ready();
    #1;
    check("pad_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("pad_rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("pad_rst_s_tready", 64'(s_axis_tready), 64'd1);
    send_frame(8, 8'hFF, 8, 8'hFF, 1'b0);
    send_frame(3, 8'h0F, 8, 8'h0F, 1'b1);
    idle(1);

    guard = 0;
    while ((exp_q.size() != 0 || frm_q.size() != 0) && guard < 1000) begin
      @(negedge user_clk);
      drive_ready();
      guard++;
    end
    if (exp_q.size() != 0 || frm_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: actual=%0d_beats_left required=0", exp_q.size());
    end
    idle(3);
    #1;
`ifdef TX_PAD_STATS_EN
    check("stat_frames", 64'(stat_frames), 64'(exp_frames));
    check("stat_padded", 64'(stat_padded), 64'(exp_padded));
`else
    check("stat_frames_off", 64'(stat_frames), 64'd0);
    check("stat_padded_off", 64'(stat_padded), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
